readout_capture: RTL
====================

# readout_capture

Receive-side counterpart of `readout_buffer`. It samples the registered readout stream (`out_value` qualified by the buffer's `en`, tagged with the active `src`) and frames it into rows and a fixed number of rows per capture. It stores the tagged bytes in a small first-word-fall-through FIFO and hands them to a downstream consumer over a valid/ready handshake. It sits between the pixel/memory readout path and the host-side logger or memory writer.

## Interface
- `ROW_LEN`, 8: bytes per row; must be ≥2.
- `NUM_ROWS`, 4: rows per capture; must be ≥1.
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that arms a capture; honoured only in IDLE.
- `in_en` in 1: input byte qualifier; connects to the readout buffer's `en`.
- `in_src` in 1: source tag, 0 = memory, 1 = pixel.
- `in_value` in 8: readout byte.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out 8: head value.
- `out_src` out 1: head source tag.
- `out_last` out 1: head is the last byte of a row.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; set when a byte is dropped.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a capture completes.
- `row_csum` out 8: XOR checksum of the last completed row (see Configuration).

## Operation
- Reset values: state IDLE, FIFO empty, and all outputs 0 (`out_valid`, `out_data`, `out_src`, `out_last`, `fifo_count`, `overflow`, `busy`, `done`, `row_csum`). Byte and row counters are 0.
- FSM states: IDLE, CAPTURE, DRAIN.
  - IDLE → CAPTURE on `start`. The same edge clears the byte counter, the row counter and `overflow`.
  - CAPTURE → DRAIN on the edge that accepts byte `ROW_LEN-1` of row `NUM_ROWS-1`.
  - DRAIN → IDLE when the FIFO is empty. `done` is high for the one cycle in which the state is IDLE after DRAIN.
- Push:
  - In CAPTURE with `in_en=1`, write {`last`, `in_src`, `in_value`}. `last` = (byte counter == `ROW_LEN-1`).
  - The byte counter wraps to 0 after `ROW_LEN-1`, and the row counter increments at that point.
  - `in_en` is ignored in IDLE and DRAIN.
- Pop: occurs when `out_valid && out_ready`.
- FIFO full:
  - A push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
  - A dropped byte still advances the byte and row counters, so row framing stays aligned with the source.
- Simultaneous push and pop: `fifo_count` is unchanged and both operations are performed.
- `start` outside IDLE is ignored.
- Reset mid-capture discards FIFO contents immediately, with no `done` pulse.
- Pointers are $clog2(DEPTH) bits and wrap naturally. The count is one bit wider so that full is distinguishable from empty.

## Timing
- Write-to-output latency is 1 cycle. A byte accepted at edge N appears with `out_valid=1` after edge N when the FIFO was previously empty.
- `out_data`, `out_src` and `out_last` are stable while `out_valid=1 && out_ready=0`.
- `out_valid` must not depend combinationally on `out_ready`.
- `fifo_count`, `busy` and `overflow` update on the same edge as the event that changes them.
- Throughput is one byte per cycle in and one byte per cycle out, sustained.

## Configuration
- Macro: `READOUT_CAPTURE_CHECKSUM_EN`.
- Defined:
  - An 8-bit XOR accumulator folds in every byte counted in CAPTURE, including dropped bytes.
  - On the row's last byte, `row_csum` ← accumulator ^ `in_value`, and the accumulator clears.
  - `row_csum` holds its value until the next row completes or reset.
- Undefined: `row_csum` is tied to 0 and no accumulator is built. The port is present in both builds.

## Structure
- Shared package `readout_pkg`:
  - FSM state enum (IDLE/CAPTURE/DRAIN).
  - Source tag constants `SRC_MEM=0` and `SRC_PIX=1`.
  - FIFO entry layout (10-bit {last, src, value}) and its width constant.
- One sub-module: `readout_fifo`, a parameterized FWFT synchronous FIFO with push/pop/full/empty/count and async active-high reset. The FSM, counters and checksum live in the top module.

## Test plan
- Reset then `start`, with `ROW_LEN=4`, `NUM_ROWS=2`, `out_ready=1`, and bytes 01..08 streamed with `in_en=1`, `in_src=0`:
  - Output is 01..08, with `out_last` on 04 and 08.
  - `done` pulses once after 08 drains.
  - `busy` is high from `start` to the `done` cycle.
- Hold `out_ready=0` and push 16 bytes A0..AF, then one more:
  - `fifo_count=16`.
  - The 17th byte is dropped and `overflow=1`.
  - Raising `out_ready` then yields A0..AF in order.
- With the FIFO full, push and pop in the same cycle: the push is accepted, `fifo_count` stays 16 and `overflow` stays 0.
- Toggle `in_en` off for 3 cycles mid-row, with C3 then D4 on `in_src=1`: there are no gaps in the framing and `out_src=1` on both bytes.
- Assert `rst` mid-capture with 5 entries stored: `out_valid=0`, `fifo_count=0`, state IDLE, and no `done` pulse.
- With `READOUT_CAPTURE_CHECKSUM_EN` defined, send row 11,22,44,88 (`ROW_LEN=4`): `row_csum=FF`. Without the macro, `row_csum=00`.

Source files
------------

// File: rtl/readout_pkg.sv
// readout_pkg: shared FSM state type, source tags and FIFO entry layout
// for the readout capture path.
package readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  localparam logic SRC_MEM = 1'b0;
  localparam logic SRC_PIX = 1'b1;

  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic       last;
    logic       src;
    logic [7:0] value;
  } entry_t;

endpackage

// File: rtl/readout_fifo.sv
// readout_fifo: first-word-fall-through synchronous FIFO. The head entry
// is visible on rdata_o while the FIFO is non-empty and reads as zero
// when empty. A push into a full FIFO is accepted only when a pop happens
// in the same cycle.
module readout_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];
  assign count_o = count_q;

  // Pointers wrap naturally; count moves only when exactly one side acts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, head is masked when empty.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/readout_capture.sv
// readout_capture: frames the registered readout stream into rows and
// captures, queues tagged bytes in an FWFT FIFO and presents them over a
// valid/ready handshake.
// Optional feature: define READOUT_CAPTURE_CHECKSUM_EN to build the per-row
// XOR checksum on row_csum; otherwise row_csum reads 0.
module readout_capture
  import readout_pkg::*;
#(
  parameter int ROW_LEN  = 8,
  parameter int NUM_ROWS = 4,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_en,
  input  logic                   in_src,
  input  logic [7:0]             in_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_src,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             row_csum
);

  localparam int BW = $clog2(ROW_LEN);
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  state_e        state_q;
  logic [BW-1:0] byteCnt_q;
  logic [RW-1:0] rowCnt_q;
  logic          overflow_q;
  logic          done_q;
  logic          busy_q;

  logic   countByte;
  logic   rowEnd;
  logic   lastRow;
  logic   fifoFull;
  logic   fifoEmpty;
  logic   popReq;
  logic   dropByte;
  entry_t wrEntry;
  entry_t rdEntry;

  // A byte is counted whenever it is qualified during CAPTURE, even if dropped.
  assign countByte = (state_q == ST_CAPTURE) && in_en;
  assign rowEnd    = (byteCnt_q == BW'(ROW_LEN - 1));
  assign lastRow   = (rowCnt_q == RW'(NUM_ROWS - 1));
  assign popReq    = out_valid && out_ready;
  assign dropByte  = countByte && fifoFull && !popReq;
  assign wrEntry   = {rowEnd, in_src, in_value};

  readout_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (countByte),
    .wdata_i (wrEntry),
    .pop_i   (popReq),
    .rdata_o (rdEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifo_count)
  );

  assign out_valid = !fifoEmpty;
  assign out_data  = rdEntry.value;
  assign out_src   = rdEntry.src;
  assign out_last  = rdEntry.last;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Capture FSM with row/byte framing counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byteCnt_q  <= '0;
      rowCnt_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_CAPTURE;
            busy_q     <= 1'b1;
            byteCnt_q  <= '0;
            rowCnt_q   <= '0;
            overflow_q <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (countByte) begin
            if (dropByte) overflow_q <= 1'b1;
            if (rowEnd) begin
              byteCnt_q <= '0;
              if (lastRow) begin
                rowCnt_q <= '0;
                state_q  <= ST_DRAIN;
              end else begin
                rowCnt_q <= rowCnt_q + RW'(1);
              end
            end else begin
              byteCnt_q <= byteCnt_q + BW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (fifoEmpty) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef READOUT_CAPTURE_CHECKSUM_EN
  logic [7:0] acc_q;
  logic [7:0] rowCsum_q;

  // Row checksum: fold every counted byte, publish and clear at row end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= 8'h00;
      rowCsum_q <= 8'h00;
    end else if ((state_q == ST_IDLE) && start) begin
      acc_q <= 8'h00;
    end else if (countByte) begin
      if (rowEnd) begin
        rowCsum_q <= acc_q ^ in_value;
        acc_q     <= 8'h00;
      end else begin
        acc_q <= acc_q ^ in_value;
      end
    end
  end

  assign row_csum = rowCsum_q;
`else
  assign row_csum = 8'h00;
`endif

endmodule
